// File: rtl/spi_pkg.sv
// Shared definitions for the two-requester SPI master: FSM encodings,
// default timing/width values, the SPI mode constant and the arbiter pick rule.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int CLK_DIV_DEFAULT = 4;
    localparam int DATA_W_DEFAULT  = 8;

    // SPI mode 0: CPOL=0 (SCLK idles low), CPHA=0 (sample on the rising edge).
    localparam int   SPI_MODE  = 0;
    localparam logic SCLK_IDLE = (SPI_MODE >= 2);

    // Round-robin pick between two requesters. Returns the winning index.
    // When both request, the pointer decides; a lone request always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Bit-level SPI engine: SCLK half-period divider, half-period counter and
// the combined TX/RX shift register. Timing is driven by 'en' from the FSM;
// the first CLK_DIV cycles of an enabled run are the setup phase (SCLK idle),
// after which SCLK toggles every CLK_DIV cycles starting with a rise.
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              en,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              tick,
    output logic              last,
    output logic [DATA_W-1:0] rx
);

    localparam int HALF_W = $clog2(2 * DATA_W + 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);

    // shreg[DATA_W] drives MOSI; shreg[0] is the landing slot for the MISO
    // sample taken on the rise, pushed up into the data field on the fall.
    logic [DATA_W:0]   shreg;
    logic [7:0]        div_cnt;
    logic [HALF_W-1:0] half_cnt;

    assign tick = en && (div_cnt == DIV_LAST);
    assign last = tick && (half_cnt == HALF_LAST);
    assign mosi = shreg[DATA_W];
    assign rx   = shreg[DATA_W:1];

    // Divider, half-period counter, SCLK toggling and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= SCLK_IDLE;
        end else if (load) begin
            shreg    <= {load_data, 1'b0};
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= SCLK_IDLE;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                if (half_cnt != HALF_LAST) begin
                    half_cnt <= half_cnt + 1'b1;
                    if (!half_cnt[0]) begin
                        sclk     <= ~SCLK_IDLE;
                        shreg[0] <= miso;
                    end else begin
                        sclk  <= SCLK_IDLE;
                        shreg <= {shreg[DATA_W-1:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Two-requester SPI master: round-robin arbiter plus transfer FSM
// (IDLE -> SETUP -> SHIFT -> DONE -> GAP). The bit engine lives in
// spi_master_shifter.
//
// Requester protocol: req[i] is a level sampled only in IDLE. The winner
// sees gnt[i] from the cycle after sampling until the end of the DONE cycle;
// its tx_data is captured at the sampling edge. done[i] pulses for exactly
// one cycle (while gnt[i] is still high) and rx_data is valid from that
// cycle until the next done. Dropping req after the grant does not abort.
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] tx_data0,
    input  logic [DATA_W-1:0] tx_data1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    output logic              SS,
    input  logic              MISO,
    output logic [2:0]        dbg_state
);

    localparam logic [7:0] GAP_LAST = 8'(CLK_DIV - 1);

    state_t            state;
    logic              ptr;
    logic [7:0]        gap_cnt;
    logic              win;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              shift_en;
    logic              shift_mosi;
    logic              tick;
    logic              last;
    logic [DATA_W-1:0] shift_rx;

    assign win       = rr_pick(req, ptr);
    assign load      = (state == ST_IDLE) && (req != 2'b00);
    assign load_data = win ? tx_data1 : tx_data0;
    assign shift_en  = (state == ST_SETUP) || (state == ST_SHIFT);
    assign dbg_state = state;

    // The data line is forced low whenever the slave is deselected.
    assign MOSI = SS ? 1'b0 : shift_mosi;

    spi_master_shifter #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .en        (shift_en),
        .miso      (MISO),
        .sclk      (SCLK),
        .mosi      (shift_mosi),
        .tick      (tick),
        .last      (last),
        .rx        (shift_rx)
    );

    // Transfer FSM with arbitration and all registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            SS      <= 1'b1;
            rx_data <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt   <= win ? 2'b10 : 2'b01;
                        ptr   <= ~win;
                        SS    <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (last) begin
                        SS      <= 1'b1;
                        done    <= gnt;
                        rx_data <= shift_rx;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt     <= 2'b00;
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a CLK_DIV=4 instance carries the
// functional and cycle-timing checks, a CLK_DIV=2 instance the SCLK phase
// checks. Expected transfers are queued at stimulus time and popped by a
// monitor on every done pulse.
module tb_spi_master_arbiter;
    import spi_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] tx_data0, tx_data1;
    wire  [1:0] gnt, done;
    wire  [7:0] rx_data;
    wire        busy, SCLK, MOSI, SS, MISO;
    wire  [2:0] dbg_state;

    logic [1:0] req2;
    wire  [1:0] gnt2, done2;
    wire  [7:0] rx_data2;
    wire        busy2, SCLK2, MOSI2, SS2;
    wire        MISO2 = 1'b1;
    wire  [2:0] dbg_state2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    spi_master_arbiter #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
        .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy), .SCLK(SCLK),
        .MOSI(MOSI), .SS(SS), .MISO(MISO), .dbg_state(dbg_state)
    );

    spi_master_arbiter #(.CLK_DIV(2), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .tx_data0(8'h5A), .tx_data1(8'hA5),
        .gnt(gnt2), .done(done2), .rx_data(rx_data2), .busy(busy2), .SCLK(SCLK2),
        .MOSI(MOSI2), .SS(SS2), .MISO(MISO2), .dbg_state(dbg_state2)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    int done_pulses = 0;
    int inv_bad = 0;
    logic [17:0] exp_q[$];      // {done, tx byte, rx byte}
    logic [17:0] exp_e;
    logic [7:0]  slave_q[$];
    logic [7:0]  slave_cur = 8'h00;
    logic [2:0]  sidx = 3'd0;
    logic [7:0]  mosi_cap = 8'h00;

    int c0, g_rel, len, hi_rel;
    logic [1:0] g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- SPI slave model (mode 0) ----------------
    always @(negedge SS) begin
        slave_cur = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        sidx = 3'd7;
    end
    always @(negedge SCLK) sidx = sidx - 3'd1;
    assign MISO = SS ? 1'b0 : slave_cur[sidx];

    always @(posedge SCLK) if (!SS) mosi_cap = {mosi_cap[6:0], MOSI};

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done != 2'b00) begin
            last_done_cyc = cyc;
            done_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected_done: got done=%b, expected no transfer", done);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_done", 32'(done), 32'(exp_e[17:16]));
                check("sb_rx", 32'(rx_data), 32'(exp_e[7:0]));
                check("sb_mosi", 32'(mosi_cap), 32'(exp_e[15:8]));
            end
        end
        if (SS && (SCLK || MOSI)) inv_bad++;
        if (SS2 && (SCLK2 || MOSI2)) inv_bad++;
    end

    // ---------------- CLK_DIV=2 phase monitor ----------------
    int  run2 = 0, rises2 = 0, hi_run2 = 0, phase_bad = 0, gap_bad = 0, gaps_checked = 0;
    logic lvl2 = 1'b0, in_win2 = 1'b0, seen_win2 = 1'b0;
    int  win_rises[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_win2 = 1'b0;
            hi_run2 = 0;
        end else if (!SS2) begin
            if (!in_win2) begin
                if (seen_win2) begin
                    gaps_checked++;
                    if (hi_run2 < 3) gap_bad++;
                end
                in_win2 = 1'b1; seen_win2 = 1'b1;
                lvl2 = SCLK2; run2 = 1; rises2 = 0;
            end else if (SCLK2 == lvl2) begin
                run2++;
            end else begin
                if (run2 != 2) phase_bad++;
                if (SCLK2) rises2++;
                lvl2 = SCLK2; run2 = 1;
            end
        end else begin
            if (in_win2) begin
                if (run2 != 2) phase_bad++;
                win_rises.push_back(rises2);
                in_win2 = 1'b0;
                hi_run2 = 0;
            end
            hi_run2++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (busy) note_timeout("wait_idle");
    endtask

    // Follows one grant: returns its value, first cycle, length and the
    // first cycle SCLK was seen high (relative to cycle-0 stamp c_ref).
    task automatic track_xfer(input int c_ref, output logic [1:0] gv, output int at,
                              output int n, output int hi);
        int guard = 0;
        gv = 2'b00; at = -1; n = 0; hi = -1;
        @(negedge clk);
        while (gnt == 2'b00 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (gnt == 2'b00) begin
            note_timeout("gnt_wait");
            return;
        end
        gv = gnt;
        at = cyc - c_ref;
        while (gnt != 2'b00 && n < 300) begin
            n++;
            if (SCLK && hi < 0) hi = cyc - c_ref;
            @(negedge clk);
        end
    endtask

    // One transfer with req asserted for a single IDLE cycle.
    task automatic run_one(input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] sb, input logic [1:0] gexp, input string tag);
        wait_idle();
        @(negedge clk);
        tx_data0 = d0; tx_data1 = d1; req = rv; c0 = cyc;
        slave_q.push_back(sb);
        exp_q.push_back({gexp, (gexp[1] ? d1 : d0), sb});
        fork
            track_xfer(c0, g, g_rel, len, hi_rel);
            begin @(negedge clk); req = 2'b00; end
        join
        check({tag, "_gnt"}, 32'(g), 32'(gexp));
        check({tag, "_len"}, 32'(len), 32'd69);
        check({tag, "_done_at"}, 32'(last_done_cyc - c0), 32'd69);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int pre_done;
        req = 2'b00; req2 = 2'b00; tx_data0 = 8'h00; tx_data1 = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ss", 32'(SS), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // simultaneous requests held: 01, 10, 01
        wait_idle();
        @(negedge clk);
        tx_data0 = 8'h11; tx_data1 = 8'h22; req = 2'b11; c0 = cyc;
        slave_q.push_back(8'h5A); slave_q.push_back(8'hC3); slave_q.push_back(8'h96);
        exp_q.push_back({2'b01, 8'h11, 8'h5A});
        exp_q.push_back({2'b10, 8'h22, 8'hC3});
        exp_q.push_back({2'b01, 8'h11, 8'h96});
        track_xfer(c0, g, g_rel, len, hi_rel);
        check("rr0_gnt", 32'(g), 32'b01);
        check("rr0_at", 32'(g_rel), 32'd1);
        check("rr0_len", 32'(len), 32'd69);
        check("rr0_sclk_first_hi", 32'(hi_rel), 32'd5);
        check("rr0_done_at", 32'(last_done_cyc - c0), 32'd69);
        track_xfer(c0, g, g_rel, len, hi_rel);
        check("rr1_gnt", 32'(g), 32'b10);
        check("rr1_at", 32'(g_rel), 32'd75);
        check("rr1_len", 32'(len), 32'd69);
        check("rr1_done_at", 32'(last_done_cyc - c0), 32'd143);
        track_xfer(c0, g, g_rel, len, hi_rel);
        req = 2'b00;
        check("rr2_gnt", 32'(g), 32'b01);
        check("rr2_at", 32'(g_rel), 32'd149);
        check("rr2_len", 32'(len), 32'd69);

        // lone request with pointer at requester 1; tx change after grant
        wait_idle();
        @(negedge clk);
        req = 2'b01; tx_data0 = 8'hA5; c0 = cyc;
        slave_q.push_back(8'h3C);
        exp_q.push_back({2'b01, 8'hA5, 8'h3C});
        fork
            track_xfer(c0, g, g_rel, len, hi_rel);
            begin
                @(negedge clk);
                check("single_setup_ss", 32'(SS), 32'd0);
                check("single_setup_sclk", 32'(SCLK), 32'd0);
                check("single_setup_mosi", 32'(MOSI), 32'd1);
                check("single_setup_busy", 32'(busy), 32'd1);
                check("single_setup_state", 32'(dbg_state), 32'(ST_SETUP));
                req = 2'b00; tx_data0 = 8'hFF;
            end
        join
        check("single_gnt", 32'(g), 32'b01);
        check("single_at", 32'(g_rel), 32'd1);
        check("single_len", 32'(len), 32'd69);
        check("single_sclk_first_hi", 32'(hi_rel), 32'd5);
        check("single_done_at", 32'(last_done_cyc - c0), 32'd69);
        check("single_rx_hold", 32'(rx_data), 32'h3C);
        check("single_gap_ss", 32'(SS), 32'd1);
        check("single_gap_state", 32'(dbg_state), 32'(ST_GAP));

        // pointer moved to 1 after the lone grant; then a one-cycle req0 pulse
        run_one(2'b11, 8'h3D, 8'h7E, 8'h81, 2'b10, "ptr_moved");
        run_one(2'b01, 8'h0F, 8'hE1, 8'hF0, 2'b01, "pulse_req0");

        // reset in the middle of SHIFT
        wait_idle();
        @(negedge clk);
        req = 2'b01; tx_data0 = 8'h99; c0 = cyc;
        slave_q.push_back(8'h66);
        @(negedge clk);
        req = 2'b00;
        while (cyc < c0 + 30) @(negedge clk);
        check("mid_sclk_before", 32'(SCLK), 32'd1);
        check("mid_ss_before", 32'(SS), 32'd0);
        pre_done = done_pulses;
        rst_n = 1'b0;
        #1;
        check("mid_ss", 32'(SS), 32'd1);
        check("mid_sclk", 32'(SCLK), 32'd0);
        check("mid_mosi", 32'(MOSI), 32'd0);
        check("mid_gnt", 32'(gnt), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_rx", 32'(rx_data), 32'd0);
        repeat (3) @(negedge clk);

        // first edge after reset accepts; pointer back at requester 0
        rst_n = 1'b1; req = 2'b11; tx_data0 = 8'hC6; tx_data1 = 8'h5B; c0 = cyc;
        slave_q.push_back(8'h39);
        exp_q.push_back({2'b01, 8'hC6, 8'h39});
        fork
            track_xfer(c0, g, g_rel, len, hi_rel);
            begin @(negedge clk); req = 2'b00; end
        join
        check("post_rst_gnt", 32'(g), 32'b01);
        check("post_rst_at", 32'(g_rel), 32'd1);
        check("post_rst_done_count", 32'(done_pulses - pre_done), 32'd1);

        // CLK_DIV=2 instance: two back-to-back transfers
        @(negedge clk);
        req2 = 2'b11;
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 2; i++) begin
            @(negedge clk);
            if (done2 != 2'b00) cnt++;
        end
        req2 = 2'b00;
        if (cnt < 2) note_timeout("div2_done");
        repeat (10) @(negedge clk);
        check("div2_windows", 32'(win_rises.size()), 32'd2);
        foreach (win_rises[i]) check("div2_rises", 32'(win_rises[i]), 32'd8);
        check("div2_phase_len", 32'(phase_bad), 32'd0);
        check("div2_gaps_seen", 32'(gaps_checked), 32'd1);
        check("div2_ss_gap", 32'(gap_bad), 32'd0);
        check("div2_rx", 32'(rx_data2), 32'hFF);
        check("div2_idle", 32'({busy2, gnt2, dbg_state2}), 32'd0);

        // wrap-up
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("ss_high_lines_quiet", 32'(inv_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
